// File: rtl/led_mode_sequencer.sv
// Four-mode LED sequencer: debounced mode button steps RUN -> HOLD -> CHASE -> BLINK
// and drives the enable/clear controls of an external free-running counter.
`timescale 1ns/1ps
module led_mode_sequencer #(
    parameter int unsigned EXT_CLOCK_FREQ  = 50000000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned TICK_DIV        = 12500000
) (
    input  logic        EXTCLK,
    input  logic [1:0]  KEY_n,
    input  logic [31:0] cnt_value,
    output logic        cnt_en,
    output logic        cnt_clr,
    output logic [7:0]  LEDG,
    output logic [1:0]  mode
);

    localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    // Clock frequency documents the intended tick rate only.
    localparam int unsigned unused_clk_freq = EXT_CLOCK_FREQ;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        HOLD  = 2'b01,
        CHASE = 2'b10,
        BLINK = 2'b11
    } state_t;

    logic          rst_n;
    logic          key_meta, key_sync, key_deb;
    logic [DW-1:0] deb_cnt;
    logic          press;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    state_t        state, state_nxt;
    logic [7:0]    led_nxt, snap, snap_nxt;
    logic          en_nxt, clr_nxt;
    logic          unused_cnt_bits;

    assign rst_n           = KEY_n[0];
    assign unused_cnt_bits = ^cnt_value[23:0];

    always_ff @(posedge EXTCLK or negedge rst_n) begin
        if (!rst_n) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
        end else begin
            key_meta <= KEY_n[1];
            key_sync <= key_meta;
        end
    end

    // Level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge EXTCLK or negedge rst_n) begin
        if (!rst_n) begin
            key_deb <= 1'b1;
            deb_cnt <= '0;
            press   <= 1'b0;
        end else begin
            press <= 1'b0;
            if (key_sync == key_deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                key_deb <= key_sync;
                deb_cnt <= '0;
                press   <= ~key_sync;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge EXTCLK or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (press || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge EXTCLK or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            LEDG    <= '0;
            cnt_en  <= 1'b0;
            cnt_clr <= 1'b0;
            snap    <= '0;
        end else begin
            state   <= state_nxt;
            LEDG    <= led_nxt;
            cnt_en  <= en_nxt;
            cnt_clr <= clr_nxt;
            snap    <= snap_nxt;
        end
    end

    // A press wins over a coincident tick: the tick is simply not applied.
    always_comb begin
        state_nxt = state;
        led_nxt   = LEDG;
        snap_nxt  = snap;
        en_nxt    = 1'b0;
        clr_nxt   = 1'b0;
        case (state)
            RUN: begin
                led_nxt = cnt_value[31:24];
                if (press) begin
                    state_nxt = HOLD;
                    snap_nxt  = cnt_value[31:24];
                end else begin
                    en_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (press) begin
                    state_nxt = CHASE;
                    led_nxt   = 8'h01;
                end else begin
                    led_nxt = snap;
                end
            end
            CHASE: begin
                if (press) begin
                    state_nxt = BLINK;
                    led_nxt   = 8'hFF;
                end else if (tick) begin
                    led_nxt = {LEDG[6:0], LEDG[7]};
                end
            end
            BLINK: begin
                if (press) begin
                    state_nxt = RUN;
                    clr_nxt   = 1'b1;
                    en_nxt    = 1'b1;
                    led_nxt   = cnt_value[31:24];
                end else if (tick) begin
                    led_nxt = ~LEDG;
                end
            end
        endcase
    end

    assign mode = state;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Self-checking bench for led_mode_sequencer: directed vector table, hand sequences
// for reset corner cases, then random key/counter stimulus against a reference model.
`timescale 1ns/1ps
module tb_led_mode_sequencer;

    localparam int unsigned DEB  = 4;
    localparam int unsigned TDIV = 8;

    logic        EXTCLK;
    logic [1:0]  KEY_n;
    logic [31:0] cnt_value;
    logic        cnt_en;
    logic        cnt_clr;
    logic [7:0]  LEDG;
    logic [1:0]  mode;

    int total = 0;
    int bad   = 0;

    led_mode_sequencer #(
        .EXT_CLOCK_FREQ (50000000),
        .DEBOUNCE_CYCLES(DEB),
        .TICK_DIV       (TDIV)
    ) dut (
        .EXTCLK   (EXTCLK),
        .KEY_n    (KEY_n),
        .cnt_value(cnt_value),
        .cnt_en   (cnt_en),
        .cnt_clr  (cnt_clr),
        .LEDG     (LEDG),
        .mode     (mode)
    );

    initial EXTCLK = 1'b0;
    always #5 EXTCLK = ~EXTCLK;

    // Reference model: mode index advances on each accepted press; LEDs are derived
    // from elapsed cycles since mode entry rather than from stored LED state.
    int unsigned m_state, m_edge, m_entry;
    logic        m_deb, m_press, m_clr, m_s, m_differ;
    logic [7:0]  m_run, m_snap;
    logic        raw_q[$];
    logic        syn_q[$];

    initial forever begin
        @(posedge EXTCLK or negedge KEY_n[0]);
        if (!KEY_n[0]) begin
            m_state = 0; m_edge = 0; m_entry = 0;
            m_deb = 1'b1; m_press = 1'b0; m_clr = 1'b0;
            m_run = 8'h00; m_snap = 8'h00;
            raw_q = '{1'b1, 1'b1};
            syn_q.delete();
        end else begin
            m_edge++;
            m_clr = 1'b0;
            if (m_press) begin
                if (m_state == 3) m_clr = 1'b1;
                if (m_state == 0) m_snap = cnt_value[31:24];
                m_state = (m_state + 1) % 4;
                m_entry = m_edge;
            end
            m_run = cnt_value[31:24];
            m_s = raw_q.pop_front();
            raw_q.push_back(KEY_n[1]);
            syn_q.push_back(m_s);
            if (syn_q.size() > DEB) void'(syn_q.pop_front());
            m_press  = 1'b0;
            m_differ = (syn_q.size() == DEB);
            foreach (syn_q[i]) if (syn_q[i] == m_deb) m_differ = 1'b0;
            if (m_differ) begin
                m_press = m_deb;
                m_deb   = ~m_deb;
                syn_q.delete();
            end
        end
    end

    function automatic logic [7:0] exp_led();
        int unsigned n;
        n = (m_edge - m_entry) / TDIV;
        if (m_edge == 0) return 8'h00;
        case (m_state)
            0:       return m_run;
            1:       return m_snap;
            2:       return 8'(1 << (n % 8));
            default: return (n % 2 == 0) ? 8'hFF : 8'h00;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [1:0] e_mode, input logic e_en,
                              input logic e_clr, input logic [7:0] e_led);
        check({tag, " mode"},    32'(mode),    32'(e_mode));
        check({tag, " cnt_en"},  32'(cnt_en),  32'(e_en));
        check({tag, " cnt_clr"}, 32'(cnt_clr), 32'(e_clr));
        check({tag, " LEDG"},    32'(LEDG),    32'(e_led));
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge EXTCLK);
        @(negedge EXTCLK);
    endtask

    typedef struct {
        logic        key;
        logic [31:0] cv;
        int          n;
        logic [1:0]  mode;
        logic        en;
        logic        clr;
        logic [7:0]  led;
    } vec_t;

    vec_t tbl [25];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned run_left;
        logic        key_lvl;

        tbl[0]  = '{1'b1, 32'hA512_3456, 1,  2'd0, 1'b1, 1'b0, 8'hA5};
        tbl[1]  = '{1'b1, 32'h3C00_FFFF, 1,  2'd0, 1'b1, 1'b0, 8'h3C};
        tbl[2]  = '{1'b0, 32'h3C00_FFFF, 2,  2'd0, 1'b1, 1'b0, 8'h3C};
        tbl[3]  = '{1'b1, 32'h3C00_FFFF, 6,  2'd0, 1'b1, 1'b0, 8'h3C};
        tbl[4]  = '{1'b0, 32'h7700_0000, 7,  2'd1, 1'b0, 1'b0, 8'h77};
        tbl[5]  = '{1'b0, 32'h1234_5678, 10, 2'd1, 1'b0, 1'b0, 8'h77};
        tbl[6]  = '{1'b1, 32'h9ABC_DEF0, 8,  2'd1, 1'b0, 1'b0, 8'h77};
        tbl[7]  = '{1'b0, 32'h9ABC_DEF0, 7,  2'd2, 1'b0, 1'b0, 8'h01};
        tbl[8]  = '{1'b1, 32'h9ABC_DEF0, 7,  2'd2, 1'b0, 1'b0, 8'h01};
        tbl[9]  = '{1'b1, 32'h9ABC_DEF0, 1,  2'd2, 1'b0, 1'b0, 8'h02};
        tbl[10] = '{1'b1, 32'h9ABC_DEF0, 8,  2'd2, 1'b0, 1'b0, 8'h04};
        tbl[11] = '{1'b1, 32'h9ABC_DEF0, 8,  2'd2, 1'b0, 1'b0, 8'h08};
        tbl[12] = '{1'b1, 32'h9ABC_DEF0, 8,  2'd2, 1'b0, 1'b0, 8'h10};
        tbl[13] = '{1'b1, 32'h9ABC_DEF0, 8,  2'd2, 1'b0, 1'b0, 8'h20};
        tbl[14] = '{1'b1, 32'h9ABC_DEF0, 8,  2'd2, 1'b0, 1'b0, 8'h40};
        tbl[15] = '{1'b1, 32'h9ABC_DEF0, 8,  2'd2, 1'b0, 1'b0, 8'h80};
        tbl[16] = '{1'b1, 32'h9ABC_DEF0, 8,  2'd2, 1'b0, 1'b0, 8'h01};
        tbl[17] = '{1'b1, 32'h9ABC_DEF0, 8,  2'd2, 1'b0, 1'b0, 8'h02};
        tbl[18] = '{1'b0, 32'h9ABC_DEF0, 7,  2'd3, 1'b0, 1'b0, 8'hFF};
        tbl[19] = '{1'b1, 32'h9ABC_DEF0, 7,  2'd3, 1'b0, 1'b0, 8'hFF};
        tbl[20] = '{1'b1, 32'h9ABC_DEF0, 1,  2'd3, 1'b0, 1'b0, 8'h00};
        tbl[21] = '{1'b1, 32'h9ABC_DEF0, 8,  2'd3, 1'b0, 1'b0, 8'hFF};
        tbl[22] = '{1'b0, 32'h5A00_0000, 6,  2'd3, 1'b0, 1'b0, 8'hFF};
        tbl[23] = '{1'b0, 32'h5A00_0000, 1,  2'd0, 1'b1, 1'b1, 8'h5A};
        tbl[24] = '{1'b1, 32'hC300_0001, 1,  2'd0, 1'b1, 1'b0, 8'hC3};

        KEY_n     = 2'b10;
        cnt_value = 32'hA512_3456;
        repeat (3) @(negedge EXTCLK);
        check_outs("in reset", 2'd0, 1'b0, 1'b0, 8'h00);
        KEY_n[0] = 1'b1;

        foreach (tbl[i]) begin
            KEY_n[1]  = tbl[i].key;
            cnt_value = tbl[i].cv;
            step(tbl[i].n);
            check_outs($sformatf("row%0d", i), tbl[i].mode, tbl[i].en, tbl[i].clr, tbl[i].led);
        end

        // Two presses from RUN reach CHASE; key stays low through a short reset pulse.
        cnt_value = 32'hE100_0000;
        repeat (2) begin
            KEY_n[1] = 1'b1;
            step(8);
            KEY_n[1] = 1'b0;
            step(8);
        end
        check_outs("chase before pulse", 2'd2, 1'b0, 1'b0, 8'h01);
        #2 KEY_n[0] = 1'b0;
        #0.5;
        check_outs("during pulse", 2'd0, 1'b0, 1'b0, 8'h00);
        #0.5 KEY_n[0] = 1'b1;
        step(1);
        check_outs("after pulse", 2'd0, 1'b1, 1'b0, 8'hE1);
        step(5);
        check_outs("held key edge6", 2'd0, 1'b1, 1'b0, 8'hE1);
        step(1);
        check_outs("held key edge7", 2'd1, 1'b0, 1'b0, 8'hE1);
        step(20);
        check_outs("held key later", 2'd1, 1'b0, 1'b0, 8'hE1);

        run_left = 0;
        key_lvl  = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if (run_left == 0) begin
                key_lvl  = 1'($urandom_range(0, 1));
                run_left = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 6);
            end
            run_left--;
            KEY_n[1]  = key_lvl;
            cnt_value = $urandom();
            if ($urandom_range(0, 299) == 0) begin
                #2 KEY_n[0] = 1'b0;
                #1 KEY_n[0] = 1'b1;
            end
            step(1);
            check("rand mode",    32'(mode),    32'(m_state));
            check("rand cnt_en",  32'(cnt_en),  32'(m_edge > 0 && m_state == 0));
            check("rand cnt_clr", 32'(cnt_clr), 32'(m_clr));
            check("rand LEDG",    32'(LEDG),    32'(exp_led()));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
